// File: rtl/md_issue.sv
// md_issue -- EX-stage issue controller for the HI/LO multiply-divide unit.
//
// Turns decoded MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO instructions into the
// unit's start/we/op/rollback handshake. It stalls IF/ID/EX while a
// multiply or divide is in flight. It requests a HI/LO rollback when the
// instruction issued last cycle faults in MEM. It also cross-checks the
// unit's busy flag against its own latency model.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   ex_valid     EX holds a valid instruction
//   ex_kind      0 NONE, 1 MUL, 2 DIV, 3 MTHI, 4 MTLO, 5 MFHI, 6 MFLO, 7 reserved
//   ex_signed    signed variant (MUL/DIV only)
//   ex_rs/ex_rt  operands; ex_rs is also the MTHI/MTLO data
//   mem_exc      instruction now in MEM faulted or was flushed
//   md_a/md_b    operands to the unit (always ex_rs/ex_rt)
//   md_op        {div, signed} for MUL/DIV; 01 selects HI, 00 selects LO for MT/MF
//   md_start     start multiply/divide
//   md_we        write HI/LO
//   md_rollback  restore HI/LO to pre-issue values
//   md_busy      unit busy flag
//   md_rd        unit read data
//   stall        freeze IF/ID/EX this cycle
//   rd_data      MFHI/MFLO result (md_rd when an MF issues, else 0)
//   div0         one-cycle pulse when a DIV issues with ex_rt == 0
//   err          sticky: md_busy disagreed with the internal latency model

module md_issue #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_kind,
  input  logic        ex_signed,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        mem_exc,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic [1:0]  md_op,
  output logic        md_start,
  output logic        md_we,
  output logic        md_rollback,
  input  logic        md_busy,
  input  logic [31:0] md_rd,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        div0,
  output logic        err
);

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_MUL  = 3'd1,
    KIND_DIV  = 3'd2,
    KIND_MTHI = 3'd3,
    KIND_MTLO = 3'd4,
    KIND_MFHI = 3'd5,
    KIND_MFLO = 3'd6,
    KIND_RSVD = 3'd7
  } kind_e;

  localparam logic [3:0] MulLat = 4'(MUL_LAT);
  localparam logic [3:0] DivLat = 4'(DIV_LAT);

  kind_e kind;

  logic [3:0] cnt_q, cnt_d;
  logic       pend_q, pend_d;
  logic       err_q, err_d;

  logic busy_l;
  logic is_mul, is_div, is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic is_md, issue;
  logic start_raw, we_raw, rollback_raw;

  assign kind   = kind_e'(ex_kind);
  assign busy_l = (cnt_q != 4'd0);

  assign md_a = ex_rs;
  assign md_b = ex_rt;

  // Instruction class decode; the reserved encoding falls through as NONE.
  always_comb begin
    is_mul  = 1'b0;
    is_div  = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    if (ex_valid) begin
      unique case (kind)
        KIND_MUL:  is_mul  = 1'b1;
        KIND_DIV:  is_div  = 1'b1;
        KIND_MTHI: is_mthi = 1'b1;
        KIND_MTLO: is_mtlo = 1'b1;
        KIND_MFHI: is_mfhi = 1'b1;
        KIND_MFLO: is_mflo = 1'b1;
        default:   ;
      endcase
    end
  end

  assign is_md = is_mul | is_div | is_mthi | is_mtlo | is_mfhi | is_mflo;

  // A faulting MEM instruction squashes the younger EX instruction.
  assign issue        = is_md & ~busy_l & ~mem_exc;
  assign start_raw    = issue & (is_mul | is_div);
  assign we_raw       = issue & (is_mthi | is_mtlo);
  assign rollback_raw = pend_q & mem_exc;

  // Operation select: MUL/DIV carry {div, signed}; MT/MF pick HI (01) or LO (00).
  always_comb begin
    md_op = 2'b00;
    if (is_mul)                     md_op = {1'b0, ex_signed};
    else if (is_div)                md_op = {1'b1, ex_signed};
    else if (is_mthi || is_mfhi)    md_op = 2'b01;
    else                            md_op = 2'b00;
  end

  // Handshake and pipeline outputs are held inactive while reset is low,
  // whatever EX presents.
  always_comb begin
    md_start    = 1'b0;
    md_we       = 1'b0;
    md_rollback = 1'b0;
    stall       = 1'b0;
    div0        = 1'b0;
    rd_data     = 32'd0;
    if (reset) begin
      md_start    = start_raw;
      md_we       = we_raw;
      md_rollback = rollback_raw;
      stall       = is_md & busy_l;
      div0        = start_raw & is_div & (ex_rt == 32'd0);
      if (issue && (is_mfhi || is_mflo)) rd_data = md_rd;
    end
  end

  // Next state: rollback wins over both the countdown and a new start, since
  // the operation it cancels is the one the counter is tracking.
  always_comb begin
    cnt_d  = cnt_q;
    pend_d = start_raw | we_raw;
    err_d  = err_q | (md_busy != busy_l);
    if (rollback_raw) begin
      cnt_d  = 4'd0;
      pend_d = 1'b0;
    end else if (start_raw) begin
      cnt_d = is_div ? DivLat : MulLat;
    end else if (busy_l) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= 4'd0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule
